muldiv_seq_ctrl: RTL and testbench
==================================

Name: muldiv_seq_ctrl

Overview:
Multi-cycle sequencer for the RV32M multiply/divide ops (OP opcode, fun7 = 0000001), alongside the single-cycle ALU in EX.
- Accepts one operation through a valid/ready handshake and iterates an internal shift-add / restoring-divide datapath one bit per cycle.
- Presents the result through a valid/ready response port.
- The pipeline holds EX while `busy` is high.
- `flush` aborts in-flight work on redirect.

Parameters:
- DATA_WIDTH, 32, operand/result width; also the iteration count.
- CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous abort of any in-flight op
- req_valid  input  1  op request
- req_ready  output  1  sequencer can accept an op
- req_fun3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- req_op_a  input  DATA_WIDTH  rs1 value
- req_op_b  input  DATA_WIDTH  rs2 value
- resp_valid  output  1  result available
- resp_ready  input  1  consumer takes result
- resp_data  output  DATA_WIDTH  result
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous, active-high, port `rst`.
- Reset values: state = IDLE; req_ready = 1; resp_valid = 0; resp_data = 0; busy = 0; counter and internal registers = 0.

States:
- IDLE: req_ready = 1. On req_valid, latch fun3 and operands.
  - Signed variants: record the sign of the result and store operand magnitudes.
    - MULH: both operands signed.
    - MULHSU: only op_a signed.
    - DIV/REM: both operands signed.
  - Special divide cases go directly to DONE.
  - All other ops go to CALC with counter = 0.
- CALC: one iteration per cycle, DATA_WIDTH cycles total; counter increments each cycle. Leave to FIX when counter == DATA_WIDTH-1.
  - Multiply: 2*DATA_WIDTH-bit accumulator; add the multiplicand when the current multiplier LSB is 1, then shift right.
  - Divide: shift the remainder left, bring in the next dividend bit, trial-subtract the divisor, set the quotient bit when the result is non-negative.
- FIX: one cycle.
  - Apply two's-complement negation where the sign requires it.
    - Quotient: negate if the operand signs differ.
    - Remainder: takes the dividend's sign.
    - Product: negate the full 2*DATA_WIDTH value.
  - Select the result field: MUL low half; MULH/MULHSU/MULHU high half; DIV/DIVU quotient; REM/REMU remainder.
  - Register the result into resp_data. Go to DONE.
- DONE: resp_valid = 1; resp_data is held stable until resp_ready. On resp_valid & resp_ready, go to IDLE.

Latency:
- Normal op: accept edge at cycle 0; CALC spans cycles 1..DATA_WIDTH; FIX at DATA_WIDTH+1; resp_valid first seen high in cycle DATA_WIDTH+2 (34 for the default).
- Special divide cases: resp_valid high the cycle after accept.

Special divide cases:
- Divisor == 0: quotient = all ones; remainder = dividend (signed and unsigned).
- Signed overflow, DIV/REM with dividend = most-negative value and divisor = all ones: quotient = dividend; remainder = 0.

Boundary conditions:
- No new request is accepted until the response handshake completes; req_ready is low in CALC, FIX and DONE. There is no accept in the same cycle as the response handshake.
- flush in any state: next state IDLE; resp_valid drops next cycle; the result is discarded.
- flush outranks a same-cycle request accept and a same-cycle response handshake; both are ignored.
- rst outranks flush.
- Operand inputs may change after accept without affecting the result.
- fun7 qualification is upstream; this block only sees req_fun3.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- When defined:
  - Multiply exits CALC to FIX once the remaining multiplier bits are all zero; the product is realigned by the remaining shift count in FIX.
  - Divide with |op_a| < |op_b| (unsigned magnitudes) goes IDLE to DONE directly with quotient 0 and remainder op_a.
  - Latency becomes variable, at least 1 cycle and at most DATA_WIDTH+2.
- When undefined: fixed latency as above (special divide cases excepted). The early-out logic is absent.

Test Plan:
- MUL 7 × 0xFFFFFFFD → resp_data 0xFFFFFFEB; resp_valid exactly 34 cycles after accept; req_ready low throughout.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU same operands → 0x40000000; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU → 2.
- DIVU 5 / 0 → 0xFFFFFFFF and REMU → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM → 0; each with resp_valid 1 cycle after accept.
- Hold resp_ready low 5 cycles in DONE → resp_valid and resp_data stable; req_valid ignored; release → IDLE next cycle, next op accepted.
- flush in CALC cycle 10 → resp_valid never rises; req_ready high and busy low the following cycle. Separately, flush with req_valid in IDLE → no accept. With MULDIV_EARLY_OUT_EN, MUL 5 × 1 → result 5 in fewer than 34 cycles.

Source files
------------

// File: rtl/muldiv_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq_ctrl
// Purpose  : Multi-cycle sequencer for the RV32M multiply/divide ops. Runs
//            one shift-add (multiply) or restoring-divide step per cycle
//            beside the single-cycle EX ALU. Results go out on a
//            valid/ready response port.
// Revision : 1.0 - initial release
//
// Ports
//   clk         in   core clock
//   rst         in   synchronous active-high reset
//   flush       in   synchronous abort of any in-flight op (pipeline redirect)
//   req_valid   in   op request
//   req_ready   out  sequencer can accept an op (IDLE only)
//   req_fun3    in   000 MUL 001 MULH 010 MULHSU 011 MULHU
//                    100 DIV 101 DIVU 110 REM 111 REMU
//   req_op_a    in   rs1 value
//   req_op_b    in   rs2 value
//   resp_valid  out  result available (DONE)
//   resp_ready  in   consumer takes result
//   resp_data   out  result, held stable while resp_valid is high
//   busy        out  high in any state other than IDLE (EX stall)
//
// Build option
//   MULDIV_EARLY_OUT_EN : when defined, the multiply leaves CALC as soon as
//   the remaining multiplier bits are zero, and a divide with
//   |op_a| < |op_b| skips straight to DONE. When undefined, latency is fixed
//   at DATA_WIDTH+2 cycles (special divide cases excepted).
// ============================================================================
module muldiv_seq_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_fun3,
  input  logic [DATA_WIDTH-1:0] req_op_a,
  input  logic [DATA_WIDTH-1:0] req_op_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  busy
);

  localparam int C_PW = 2 * DATA_WIDTH;

  localparam logic [CNT_WIDTH-1:0] C_CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] C_MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Operation context captured at accept
  logic [2:0]            r_fun3;
  logic                  r_neg_res;   // negate product / quotient in FIX
  logic                  r_neg_rem;   // negate remainder in FIX
  logic [DATA_WIDTH-1:0] r_mcand;     // multiplicand or divisor magnitude
  // Multiply: {partial product, remaining multiplier bits}
  // Divide  : {partial remainder, dividend bits shifting into quotient}
  logic [C_PW-1:0]       r_acc;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [DATA_WIDTH-1:0] r_resp_data;

  // --------------------------------------------------------------------------
  // Request decode and operand conditioning
  // --------------------------------------------------------------------------
  logic                  w_is_div;
  logic                  w_sgn_a_op;
  logic                  w_sgn_b_op;
  logic                  w_sign_a;
  logic                  w_sign_b;
  logic [DATA_WIDTH-1:0] w_mag_a;
  logic [DATA_WIDTH-1:0] w_mag_b;
  logic                  w_div_zero;
  logic                  w_div_ovf;
  logic                  w_div_small;
  logic                  w_special;
  logic [DATA_WIDTH-1:0] w_special_res;

  always_comb begin
    w_is_div   = req_fun3[2];
    // op_a signed for MULH, MULHSU, DIV, REM; op_b signed for MULH, DIV, REM
    w_sgn_a_op = (req_fun3 == 3'b001) || (req_fun3 == 3'b010) ||
                 (req_fun3 == 3'b100) || (req_fun3 == 3'b110);
    w_sgn_b_op = (req_fun3 == 3'b001) || (req_fun3 == 3'b100) ||
                 (req_fun3 == 3'b110);
    w_sign_a   = w_sgn_a_op & req_op_a[DATA_WIDTH-1];
    w_sign_b   = w_sgn_b_op & req_op_b[DATA_WIDTH-1];
    w_mag_a    = w_sign_a ? (-req_op_a) : req_op_a;
    w_mag_b    = w_sign_b ? (-req_op_b) : req_op_b;

    w_div_zero = w_is_div && (req_op_b == '0);
    w_div_ovf  = w_is_div && !req_fun3[0] &&
                 (req_op_a == C_MOST_NEG) && (req_op_b == '1);
`ifdef MULDIV_EARLY_OUT_EN
    w_div_small = w_is_div && (w_mag_a < w_mag_b);
`else
    w_div_small = 1'b0;
`endif
    w_special  = w_div_zero || w_div_ovf || w_div_small;

    // fun3[1] separates REM/REMU from DIV/DIVU
    if (w_div_zero) begin
      w_special_res = req_fun3[1] ? req_op_a : '1;
    end else if (w_div_ovf) begin
      w_special_res = req_fun3[1] ? '0 : req_op_a;
    end else begin
      w_special_res = req_fun3[1] ? req_op_a : '0;
    end
  end

  // --------------------------------------------------------------------------
  // Iteration datapath
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH:0]   w_mul_sum;
  logic [C_PW-1:0]       w_mul_next;
  logic [DATA_WIDTH:0]   w_rem_sh;
  logic [DATA_WIDTH:0]   w_diff;
  logic [C_PW-1:0]       w_div_next;
  logic                  w_mul_stop;

  always_comb begin
    w_mul_sum  = {1'b0, r_acc[C_PW-1:DATA_WIDTH]} +
                 (r_acc[0] ? {1'b0, r_mcand} : '0);
    w_mul_next = {w_mul_sum, r_acc[DATA_WIDTH-1:1]};

    // Partial remainder stays below the divisor, so the shifted value fits in
    // DATA_WIDTH+1 bits and bit DATA_WIDTH of the difference is its sign.
    w_rem_sh   = {r_acc[C_PW-1:DATA_WIDTH], r_acc[DATA_WIDTH-1]};
    w_diff     = w_rem_sh - {1'b0, r_mcand};
    if (!w_diff[DATA_WIDTH]) begin
      w_div_next = {w_diff[DATA_WIDTH-1:0], r_acc[DATA_WIDTH-2:0], 1'b1};
    end else begin
      w_div_next = {w_rem_sh[DATA_WIDTH-1:0], r_acc[DATA_WIDTH-2:0], 1'b0};
    end
  end

`ifdef MULDIV_EARLY_OUT_EN
  // After r_cnt steps, the low DATA_WIDTH-r_cnt bits of r_acc still hold
  // unconsumed multiplier bits; once those are zero the sum is complete.
  logic [DATA_WIDTH-1:0] w_rem_mask;
  always_comb begin
    w_rem_mask = {DATA_WIDTH{1'b1}} >> r_cnt;
    w_mul_stop = !r_fun3[2] && ((r_acc[DATA_WIDTH-1:0] & w_rem_mask) == '0);
  end
`else
  assign w_mul_stop = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Sign fix-up and result selection
  // --------------------------------------------------------------------------
  logic [C_PW-1:0]       w_prod_al;
  logic [C_PW-1:0]       w_prod;
  logic [DATA_WIDTH-1:0] w_quo;
  logic [DATA_WIDTH-1:0] w_rem;
  logic [DATA_WIDTH-1:0] w_result;

`ifdef MULDIV_EARLY_OUT_EN
  // r_cnt equals DATA_WIDTH after a full run, so the shift is zero then;
  // an early exit leaves the product shifted up by the skipped steps.
  logic [CNT_WIDTH-1:0] w_shamt;
  always_comb begin
    w_shamt   = CNT_WIDTH'(DATA_WIDTH) - r_cnt;
    w_prod_al = r_acc >> w_shamt;
  end
`else
  assign w_prod_al = r_acc;
`endif

  always_comb begin
    w_prod = r_neg_res ? (-w_prod_al) : w_prod_al;
    w_quo  = r_neg_res ? (-r_acc[DATA_WIDTH-1:0]) : r_acc[DATA_WIDTH-1:0];
    w_rem  = r_neg_rem ? (-r_acc[C_PW-1:DATA_WIDTH]) : r_acc[C_PW-1:DATA_WIDTH];
    case (r_fun3)
      3'b000:                 w_result = w_prod[DATA_WIDTH-1:0];
      3'b001, 3'b010, 3'b011: w_result = w_prod[C_PW-1:DATA_WIDTH];
      3'b100, 3'b101:         w_result = w_quo;
      default:                w_result = w_rem;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_state_nxt = w_special ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (w_mul_stop || (r_cnt == C_CNT_LAST)) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (resp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // Redirect kills any accept or response handshake in the same cycle
    if (flush) begin
      w_state_nxt = S_IDLE;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fun3      <= '0;
      r_neg_res   <= 1'b0;
      r_neg_rem   <= 1'b0;
      r_mcand     <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_resp_data <= '0;
    end else if (!flush) begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_fun3    <= req_fun3;
            r_neg_res <= w_sign_a ^ w_sign_b;
            r_neg_rem <= w_sign_a;
            r_cnt     <= '0;
            if (w_is_div) begin
              r_mcand <= w_mag_b;
              r_acc   <= {{DATA_WIDTH{1'b0}}, w_mag_a};
            end else begin
              r_mcand <= w_mag_a;
              r_acc   <= {{DATA_WIDTH{1'b0}}, w_mag_b};
            end
            if (w_special) begin
              r_resp_data <= w_special_res;
            end
          end
        end
        S_CALC: begin
          if (!w_mul_stop) begin
            r_acc <= r_fun3[2] ? w_div_next : w_mul_next;
            r_cnt <= r_cnt + CNT_WIDTH'(1);
          end
        end
        S_FIX: begin
          r_resp_data <= w_result;
        end
        default: begin
        end
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign resp_valid = (r_state == S_DONE);
  assign resp_data  = r_resp_data;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_seq_ctrl
// Purpose  : Self-checking bench for muldiv_seq_ctrl: directed RV32M cases,
//            special divide cases, back-pressure, flush, then randomized ops
//            checked against a 64-bit arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_fun3;
  logic [31:0] req_op_a;
  logic [31:0] req_op_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_seq_ctrl #(
    .DATA_WIDTH(32),
    .CNT_WIDTH (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_fun3  (req_fun3),
    .req_op_a  (req_op_a),
    .req_op_b  (req_op_b),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // RV32M semantics computed with 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    logic            ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = ua * ub;            return p[31:0];  end
      3'd1: begin p = sa * sb;            return p[63:32]; end
      3'd2: begin p = sa * longint'(ub);  return p[63:32]; end
      3'd3: begin p = ua * ub;            return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf)    return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  // Issue one op, wait for the response, hold resp_ready low for 'hold'
  // cycles with a competing request pending, then complete the handshake.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_d, input int hold);
    int lat;
    bit rr_high;
    bit special;
    special = f[2] && ((b == 32'd0) ||
              (!f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
    check({tag, "_ready_idle"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_fun3 = f; req_op_a = a; req_op_b = b; resp_ready = 1'b0;
    @(posedge clk); #1;
    // Scramble inputs after accept; the result must not change
    req_valid = 1'b0; req_fun3 = 3'($urandom); req_op_a = $urandom; req_op_b = $urandom;
    lat = 1; rr_high = 1'b0;
    while (!resp_valid && lat < 200) begin
      rr_high |= req_ready;
      @(posedge clk); #1;
      lat++;
    end
    rr_high |= req_ready;
    check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
    check({tag, "_data"}, resp_data, exp_d);
    check({tag, "_ready_low"}, {31'd0, rr_high}, 32'd0);
`ifdef MULDIV_EARLY_OUT_EN
    check({tag, "_lat_range"}, {31'd0, (lat >= 1 && lat <= 34)}, 32'd1);
`else
    check({tag, "_latency"}, lat, special ? 32'd1 : 32'd34);
`endif
    if (hold > 0) begin
      req_valid = 1'b1; req_fun3 = 3'd0; req_op_a = 32'd3; req_op_b = 32'd3;
      repeat (hold) begin @(posedge clk); #1; end
      check({tag, "_hold_valid"}, {31'd0, resp_valid}, 32'd1);
      check({tag, "_hold_data"}, resp_data, exp_d);
      check({tag, "_hold_noacc"}, {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0; req_valid = 1'b0;
    check({tag, "_idle_after"}, {29'd0, resp_valid, req_ready, busy}, 32'b010);
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    bit          seen;

    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_fun3 = 3'd0;
    req_op_a = 32'd0; req_op_b = 32'd0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset_resp_data", resp_data, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    run_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    run_op("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 0);
    run_op("mulhu",  3'd3, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 0);
    run_op("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0);
    run_op("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 0);
    run_op("divu",   3'd5, 32'd100,        32'd7,         32'd14,        0);
    run_op("remu",   3'd7, 32'd100,        32'd7,         32'd2,         0);
    run_op("divu0",  3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 0);
    run_op("remu0",  3'd7, 32'd5,          32'd0,         32'd5,         0);
    run_op("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0);
    run_op("hold5",  3'd0, 32'd12345,      32'd678,       32'd8369910,   5);
    run_op("after_hold", 3'd5, 32'd1000,   32'd10,        32'd100,       0);

    // Flush in CALC cycle 10; multiplier MSB set so no early exit
    req_valid = 1'b1; req_fun3 = 3'd0; req_op_a = 32'd3; req_op_b = 32'h8000_0001;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_calc_state", {29'd0, resp_valid, req_ready, busy}, 32'b010);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; seen |= resp_valid; end
    check("flush_calc_no_resp", {31'd0, seen}, 32'd0);

    // Flush with request in IDLE: no accept
    req_valid = 1'b1; req_fun3 = 3'd5; req_op_a = 32'd9; req_op_b = 32'd0; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    check("flush_idle_noacc", {29'd0, resp_valid, req_ready, busy}, 32'b010);

    // Flush in DONE with resp_ready high: response discarded, back to IDLE
    req_valid = 1'b1; req_fun3 = 3'd7; req_op_a = 32'd9; req_op_b = 32'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("flush_done_pre", {31'd0, resp_valid}, 32'd1);
    flush = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; resp_ready = 1'b0;
    check("flush_done_post", {29'd0, resp_valid, req_ready, busy}, 32'b010);

`ifdef MULDIV_EARLY_OUT_EN
    begin
      int lat;
      req_valid = 1'b1; req_fun3 = 3'd0; req_op_a = 32'd5; req_op_b = 32'd1;
      @(posedge clk); #1;
      req_valid = 1'b0; lat = 1;
      while (!resp_valid && lat < 200) begin @(posedge clk); #1; lat++; end
      check("early_mul_data", resp_data, 32'd5);
      check("early_mul_fast", {31'd0, (lat < 34)}, 32'd1);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
    end
`endif

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
        3: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      run_op($sformatf("rand%0d_f%0d", i, f), f, a, b, ref_model(f, a, b),
             int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
